// File: rtl/s3_writeback_regfile.sv
// Architectural register file written from the S3 writeback bundle, with two
// write-through read ports and a per-register pending-write scoreboard.
module s3_writeback_regfile #(
    parameter int NREGS   = 32,
    parameter int DW      = 32,
    parameter int PEND_W  = 2,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] S3_WriteSelect,
    input  logic                     S3_WriteEnable,
    input  logic [DW-1:0]            ALU_OUT,
    input  logic [$clog2(NREGS)-1:0] ReadSelect1,
    input  logic [$clog2(NREGS)-1:0] ReadSelect2,
    output logic [DW-1:0]            ReadData1,
    output logic [DW-1:0]            ReadData2,
    output logic                     Busy1,
    output logic                     Busy2,
    input  logic                     Issue_Valid,
    input  logic                     Issue_WriteEnable,
    input  logic [$clog2(NREGS)-1:0] Issue_WriteSelect,
    output logic                     Issue_Ready
);
    localparam int SW = $clog2(NREGS);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DW-1:0]     regs_q [NREGS];
    logic [PEND_W-1:0] pend_q [NREGS];
    logic [PEND_W-1:0] pend_d [NREGS];

    logic wr_r0;
    logic wr_en;
    logic iss_r0;
    logic iss_full;
    logic iss_ready;
    logic inc;

    logic [1:0][SW-1:0] rsel;
    logic [1:0][DW-1:0] rdata;
    logic [1:0]         busy;

    assign wr_r0     = ZERO_R0 && (S3_WriteSelect == '0);
    assign wr_en     = S3_WriteEnable && !wr_r0;
    assign iss_r0    = ZERO_R0 && (Issue_WriteSelect == '0);

    // A retirement to the same register this cycle frees a slot for the issue.
    assign iss_full  = (pend_q[Issue_WriteSelect] == PEND_MAX) &&
                       !(wr_en && (S3_WriteSelect == Issue_WriteSelect));
    assign iss_ready = !Issue_WriteEnable || iss_r0 || !iss_full;
    assign inc       = Issue_Valid && Issue_WriteEnable && iss_ready && !iss_r0 && !rst;

    assign Issue_Ready = iss_ready && !rst;

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            pend_d[i] = pend_q[i];
            if (inc && (Issue_WriteSelect == SW'(i))) begin
                if (!(wr_en && (S3_WriteSelect == SW'(i)))) begin
                    pend_d[i] = pend_q[i] + PEND_ONE;
                end
            end else if (wr_en && (S3_WriteSelect == SW'(i)) && (pend_q[i] != '0)) begin
                pend_d[i] = pend_q[i] - PEND_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
                pend_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                pend_q[i] <= pend_d[i];
            end
            if (wr_en) begin
                regs_q[S3_WriteSelect] <= ALU_OUT;
            end
        end
    end

    assign rsel[0] = ReadSelect1;
    assign rsel[1] = ReadSelect2;

    // A last outstanding write retiring this cycle is covered by the bypass.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic is_r0;
        logic hit;
        assign is_r0    = ZERO_R0 && (rsel[p] == '0);
        assign hit      = S3_WriteEnable && (S3_WriteSelect == rsel[p]) && !is_r0;
        assign rdata[p] = (rst || is_r0) ? '0 : (hit ? ALU_OUT : regs_q[rsel[p]]);
        assign busy[p]  = !rst && !is_r0 && (pend_q[rsel[p]] != '0) &&
                          !(hit && (pend_q[rsel[p]] == PEND_ONE));
    end

    assign ReadData1 = rdata[0];
    assign ReadData2 = rdata[1];
    assign Busy1     = busy[0];
    assign Busy2     = busy[1];

endmodule

// File: tb/tb_s3_writeback_regfile.sv
// Self-checking bench for s3_writeback_regfile: directed scenarios plus a
// randomized run against an array-based reference model.
module tb_s3_writeback_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  S3_WriteSelect, ReadSelect1, ReadSelect2, Issue_WriteSelect;
    logic        S3_WriteEnable, Issue_Valid, Issue_WriteEnable;
    logic [31:0] ALU_OUT, ReadData1, ReadData2;
    logic        Busy1, Busy2, Issue_Ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_regs [32];
    int          m_pend [32];

    always #5 clk = ~clk;

    s3_writeback_regfile dut (
        .clk               (clk),
        .rst               (rst),
        .S3_WriteSelect    (S3_WriteSelect),
        .S3_WriteEnable    (S3_WriteEnable),
        .ALU_OUT           (ALU_OUT),
        .ReadSelect1       (ReadSelect1),
        .ReadSelect2       (ReadSelect2),
        .ReadData1         (ReadData1),
        .ReadData2         (ReadData2),
        .Busy1             (Busy1),
        .Busy2             (Busy2),
        .Issue_Valid       (Issue_Valid),
        .Issue_WriteEnable (Issue_WriteEnable),
        .Issue_WriteSelect (Issue_WriteSelect),
        .Issue_Ready       (Issue_Ready)
    );

    function automatic logic [31:0] exp_rd(input logic [4:0] sel);
        if (rst || sel == 5'd0) return 32'd0;
        if (S3_WriteEnable && S3_WriteSelect == sel) return ALU_OUT;
        return m_regs[sel];
    endfunction

    function automatic logic exp_busy(input logic [4:0] sel);
        if (rst || sel == 5'd0) return 1'b0;
        if (m_pend[sel] == 0) return 1'b0;
        if (m_pend[sel] == 1 && S3_WriteEnable && S3_WriteSelect == sel) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic exp_ready();
        if (rst) return 1'b0;
        if (!Issue_WriteEnable || Issue_WriteSelect == 5'd0) return 1'b1;
        if (m_pend[Issue_WriteSelect] == 3 &&
            !(S3_WriteEnable && S3_WriteSelect == Issue_WriteSelect)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 0;
        end
    endtask

    task automatic model_clock();
        bit inc;
        bit dec;
        if (rst) return;
        inc = Issue_Valid && Issue_WriteEnable && exp_ready() && Issue_WriteSelect != 5'd0;
        dec = S3_WriteEnable && S3_WriteSelect != 5'd0;
        if (dec) m_regs[S3_WriteSelect] = ALU_OUT;
        if (!(inc && dec && Issue_WriteSelect == S3_WriteSelect)) begin
            if (inc) m_pend[Issue_WriteSelect] = m_pend[Issue_WriteSelect] + 1;
            if (dec && m_pend[S3_WriteSelect] > 0)
                m_pend[S3_WriteSelect] = m_pend[S3_WriteSelect] - 1;
        end
    endtask

    task automatic idle();
        S3_WriteSelect = 5'd0; S3_WriteEnable = 1'b0; ALU_OUT = 32'd0;
        ReadSelect1 = 5'd0; ReadSelect2 = 5'd0;
        Issue_Valid = 1'b0; Issue_WriteEnable = 1'b0; Issue_WriteSelect = 5'd0;
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd5; ALU_OUT = 32'hA5A5A5A5;
        tick();
        idle();
        Issue_Valid = 1'b1; Issue_WriteEnable = 1'b1; Issue_WriteSelect = 5'd5;
        tick();
        idle();
        ReadSelect1 = 5'd5; ReadSelect2 = 5'd5;
        #1;
        n_checks++;
        if (ReadData1 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL pre_rst_rd1: got %h want a5a5a5a5", ReadData1); end
        n_checks++;
        if (Busy1 !== 1'b1) begin n_fail++; $display("FAIL pre_rst_busy1: got %b want 1", Busy1); end
        S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd5; ALU_OUT = 32'hFFFFFFFF;
        Issue_WriteEnable = 1'b1; Issue_WriteSelect = 5'd5;
        rst = 1'b1;
        #1;
        n_checks++;
        if (ReadData1 !== 32'd0) begin n_fail++; $display("FAIL rst_rd1: got %h want 0", ReadData1); end
        n_checks++;
        if (ReadData2 !== 32'd0) begin n_fail++; $display("FAIL rst_rd2: got %h want 0", ReadData2); end
        n_checks++;
        if (Busy1 !== 1'b0 || Busy2 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b%b want 00", Busy1, Busy2); end
        n_checks++;
        if (Issue_Ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", Issue_Ready); end
        idle();
        #1;
        rst = 1'b0;
        model_reset();
        ReadSelect1 = 5'd5; Issue_WriteEnable = 1'b1; Issue_WriteSelect = 5'd5;
        #1;
        n_checks++;
        if (ReadData1 !== 32'd0) begin n_fail++; $display("FAIL post_rst_r5: got %h want 0", ReadData1); end
        n_checks++;
        if (Busy1 !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy1: got %b want 0", Busy1); end
        n_checks++;
        if (Issue_Ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", Issue_Ready); end
        idle();
        tick();
    endtask

    task automatic test_bypass();
        idle();
        S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd3; ALU_OUT = 32'hDEADBEEF;
        ReadSelect1 = 5'd3; ReadSelect2 = 5'd3;
        #1;
        n_checks++;
        if (ReadData1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_rd1: got %h want deadbeef", ReadData1); end
        n_checks++;
        if (ReadData2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_rd2: got %h want deadbeef", ReadData2); end
        tick();
        idle();
        ReadSelect1 = 5'd3;
        #1;
        n_checks++;
        if (ReadData1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stored_r3: got %h want deadbeef", ReadData1); end
    endtask

    task automatic test_zero_r0();
        idle();
        S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd0; ALU_OUT = 32'h00001234;
        #1;
        n_checks++;
        if (ReadData1 !== 32'd0) begin n_fail++; $display("FAIL r0_bypass: got %h want 0", ReadData1); end
        tick();
        idle();
        #1;
        n_checks++;
        if (ReadData1 !== 32'd0) begin n_fail++; $display("FAIL r0_stored: got %h want 0", ReadData1); end
        for (int k = 0; k < 4; k++) begin
            Issue_Valid = 1'b1; Issue_WriteEnable = 1'b1; Issue_WriteSelect = 5'd0;
            #1;
            n_checks++;
            if (Issue_Ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready[%0d]: got %b want 1", k, Issue_Ready); end
            tick();
        end
        idle();
        #1;
        n_checks++;
        if (Busy1 !== 1'b0) begin n_fail++; $display("FAIL r0_busy: got %b want 0", Busy1); end
    endtask

    task automatic test_back_to_back();
        idle();
        Issue_Valid = 1'b1; Issue_WriteEnable = 1'b1; Issue_WriteSelect = 5'd7;
        tick();
        #1;
        n_checks++;
        if (Issue_Ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2: got %b want 1", Issue_Ready); end
        tick();
        idle();
        ReadSelect1 = 5'd7;
        #1;
        n_checks++;
        if (Busy1 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_cnt2: got %b want 1", Busy1); end
        S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd7; ALU_OUT = 32'h000000A1;
        #1;
        n_checks++;
        if (Busy1 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_first_wb: got %b want 1", Busy1); end
        tick();
        ALU_OUT = 32'h000000B2;
        #1;
        n_checks++;
        if (Busy1 !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_last_wb: got %b want 0", Busy1); end
        n_checks++;
        if (ReadData1 !== 32'h000000B2) begin n_fail++; $display("FAIL b2b_rd_last_wb: got %h want b2", ReadData1); end
        tick();
        idle();
        ReadSelect1 = 5'd7;
        #1;
        n_checks++;
        if (Busy1 !== 1'b0 || ReadData1 !== 32'h000000B2) begin
            n_fail++; $display("FAIL b2b_after: got busy %b data %h want 0 b2", Busy1, ReadData1);
        end
    endtask

    task automatic test_pend_full();
        idle();
        Issue_Valid = 1'b1; Issue_WriteEnable = 1'b1; Issue_WriteSelect = 5'd9;
        repeat (3) tick();
        ReadSelect2 = 5'd9;
        #1;
        n_checks++;
        if (Issue_Ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", Issue_Ready); end
        n_checks++;
        if (Busy2 !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b want 1", Busy2); end
        tick();
        S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd9; ALU_OUT = 32'h000000C3;
        #1;
        n_checks++;
        if (Issue_Ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_with_wb: got %b want 1", Issue_Ready); end
        tick();
        S3_WriteEnable = 1'b0;
        #1;
        n_checks++;
        if (Issue_Ready !== 1'b0) begin n_fail++; $display("FAIL full_count_kept: got %b want 0", Issue_Ready); end
        idle();
        S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd9;
        repeat (3) tick();
        idle();
        ReadSelect2 = 5'd9;
        #1;
        n_checks++;
        if (Busy2 !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b want 0", Busy2); end
    endtask

    task automatic test_independent();
        idle();
        Issue_Valid = 1'b1; Issue_WriteEnable = 1'b1; Issue_WriteSelect = 5'd6;
        tick();
        idle();
        Issue_Valid = 1'b1; Issue_WriteEnable = 1'b1; Issue_WriteSelect = 5'd4;
        S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd6; ALU_OUT = 32'h00000066;
        tick();
        idle();
        ReadSelect1 = 5'd4; ReadSelect2 = 5'd6;
        #1;
        n_checks++;
        if (Busy1 !== 1'b1) begin n_fail++; $display("FAIL indep_r4_busy: got %b want 1", Busy1); end
        n_checks++;
        if (Busy2 !== 1'b0) begin n_fail++; $display("FAIL indep_r6_busy: got %b want 0", Busy2); end
        n_checks++;
        if (ReadData2 !== 32'h00000066) begin n_fail++; $display("FAIL indep_r6_data: got %h want 66", ReadData2); end
        S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd4;
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            S3_WriteEnable    = 1'($urandom_range(0, 1));
            S3_WriteSelect    = 5'($urandom_range(0, 7));
            ALU_OUT           = $urandom;
            ReadSelect1       = 5'($urandom_range(0, 7));
            ReadSelect2       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            Issue_Valid       = 1'($urandom_range(0, 1));
            Issue_WriteEnable = ($urandom_range(0, 3) != 0);
            Issue_WriteSelect = 5'($urandom_range(0, 7));
            #1;
            n_checks++;
            if (ReadData1 !== exp_rd(ReadSelect1)) begin n_fail++; $display("FAIL rand_rd1 cyc %0d: got %h want %h", n, ReadData1, exp_rd(ReadSelect1)); end
            n_checks++;
            if (ReadData2 !== exp_rd(ReadSelect2)) begin n_fail++; $display("FAIL rand_rd2 cyc %0d: got %h want %h", n, ReadData2, exp_rd(ReadSelect2)); end
            n_checks++;
            if (Busy1 !== exp_busy(ReadSelect1)) begin n_fail++; $display("FAIL rand_busy1 cyc %0d: got %b want %b", n, Busy1, exp_busy(ReadSelect1)); end
            n_checks++;
            if (Busy2 !== exp_busy(ReadSelect2)) begin n_fail++; $display("FAIL rand_busy2 cyc %0d: got %b want %b", n, Busy2, exp_busy(ReadSelect2)); end
            n_checks++;
            if (Issue_Ready !== exp_ready()) begin n_fail++; $display("FAIL rand_ready cyc %0d: got %b want %b", n, Issue_Ready, exp_ready()); end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_bypass();
        test_zero_r0();
        test_back_to_back();
        test_pend_full();
        test_independent();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
